nco_voice_mixer: RTL and testbench
==================================

NCO_VOICE_MIXER -- requirements
Module: nco_voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of independent voices, legal range 1..16.
REQ-002 Parameter PHASE_W, default 24: phase accumulator and FCW width.
REQ-003 Parameter LUT_ADDR_W, default 8: LUT index width, taken from phase[PHASE_W-1 -: LUT_ADDR_W].
REQ-004 Parameter SAMPLE_W, default 20: two's-complement LUT entry and output width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sample_tick  input  1  single-cycle pulse requesting the next mixed sample.
REQ-008 fcw  input  NUM_VOICES*PHASE_W  packed per-voice frequency control words; voice v at bits [v*PHASE_W +: PHASE_W].
REQ-009 voice_en  input  NUM_VOICES  per-voice enable mask.
REQ-010 sine_shift, square_shift, triangle_shift, sawtooth_shift  input  5 each  global per-waveform right-shift attenuation.
REQ-011 sample_out  output  SAMPLE_W  mixed, saturated signed sample.
REQ-012 sample_valid  output  1  sample_out holds a new sample.
REQ-013 sample_ready  input  1  consumer accepts sample when high with sample_valid.
REQ-014 overrun  output  1  sticky: a sample_tick arrived while the block was busy.
REQ-015 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-016 FSM states IDLE, MIX, HOLD; IDLE->MIX on sample_tick; MIX->HOLD after voice index reaches NUM_VOICES-1; HOLD->IDLE on sample_valid && sample_ready.
REQ-017 MIX processes one voice per cycle, voice 0 first; the accumulator clears on IDLE->MIX.
REQ-018 Per voice: addr = current phase top LUT_ADDR_W bits; contribution = (sine_lut[addr]>>>sine_shift) + (square_lut[addr]>>>square_shift) + (triangle_lut[addr]>>>triangle_shift) + (sawtooth_lut[addr]>>>sawtooth_shift).
REQ-019 Shift amount >= SAMPLE_W yields a zero term (not -1) for that waveform.
REQ-020 Accumulator width SAMPLE_W+2+clog2(NUM_VOICES); no internal overflow possible.
REQ-021 On entry to HOLD, sample_out = accumulator saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; sample_valid asserts same cycle.
REQ-022 Latency: tick at cycle T -> sample_valid high at cycle T+NUM_VOICES+1.
REQ-023 sample_out and sample_valid are stable during HOLD until handshake; sample_valid deasserts the cycle after acceptance.
REQ-024 Enabled voice: phase <= phase + fcw (mod 2^PHASE_W) in the cycle the voice is processed; the lookup uses the pre-update phase.
REQ-025 Disabled voice: contributes 0, phase held; voice_en sampled when each voice is processed.
REQ-026 sample_tick in MIX or HOLD is dropped and sets overrun; simultaneous clr_overrun and a dropped tick leaves overrun set.
REQ-027 LUTs are four internal arrays sine_lut, square_lut, triangle_lut, sawtooth_lut of 2^LUT_ADDR_W x SAMPLE_W, loadable by hierarchical $readmemb; read combinationally.
REQ-028 fcw and shift inputs may change any time; the value present in each processing cycle is used.

Reset
REQ-029 rst forces state IDLE, voice index 0, accumulator 0, all phases 0, sample_out 0, sample_valid 0, overrun 0.
REQ-030 rst mid-MIX or mid-HOLD aborts the sample; no sample_valid follows until a new tick after rst deasserts.
REQ-031 LUT contents are not affected by rst.

Structure
REQ-032 Package nco_pkg holds the FSM state encoding, the waveform count (4), and the saturation helper function.
REQ-033 One sub-module nco_wave_scaler: combinational per-voice LUT read, shift and four-term sum; instantiated once and time-shared across voices.

Verification
REQ-034 NUM_VOICES=1, fcw=0x010000, shifts 0, golden LUT files loaded: 256 ticks -> sample k equals golden[k], latency 2 cycles each.
REQ-035 NUM_VOICES=4, all voices fcw=0x010000, shifts 0, full-scale LUT entries -> sample_out saturates at 0x7FFFF / 0x80000, never wraps.
REQ-036 voice_en=4'b0101, shifts 0 -> output equals sum of voices 0 and 2 only; phases of voices 1 and 3 unchanged after 10 ticks.
REQ-037 sine_shift=20, others 31 -> sample_out=0 for all addresses, including negative LUT entries.
REQ-038 Hold sample_ready=0 for 8 cycles after valid, pulse sample_tick twice -> sample_out stable, overrun=1; clr_overrun -> overrun=0.
REQ-039 Assert rst 2 cycles into MIX -> all outputs 0 next cycle, no sample_valid; next tick after release yields sample of phase 0.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO voice mixer: FSM encoding,
// waveform count and output saturation.
package nco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int NUM_WAVES = 4;
    localparam int SHIFT_W   = 5;

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/nco_wave_scaler.sv
// Combinational LUT read, per-waveform attenuation and four-term sum
// for the voice currently selected by the mixer.
module nco_wave_scaler
    import nco_pkg::*;
#(
    parameter int LUT_ADDR_W = 8,
    parameter int SAMPLE_W   = 20
) (
    input  logic [LUT_ADDR_W-1:0]        addr,
    input  logic                         en,
    input  logic [NUM_WAVES*SHIFT_W-1:0] shifts,
    output logic signed [SAMPLE_W+1:0]   contrib
);

    localparam int DEPTH = 1 << LUT_ADDR_W;

    // Filled through the hierarchy; untouched by reset.
    logic [SAMPLE_W-1:0] sine_lut     [DEPTH];
    logic [SAMPLE_W-1:0] square_lut   [DEPTH];
    logic [SAMPLE_W-1:0] triangle_lut [DEPTH];
    logic [SAMPLE_W-1:0] sawtooth_lut [DEPTH];

    logic signed [SAMPLE_W-1:0] w_raw [NUM_WAVES];

    always_comb begin
        w_raw[0] = sine_lut[addr];
        w_raw[1] = square_lut[addr];
        w_raw[2] = triangle_lut[addr];
        w_raw[3] = sawtooth_lut[addr];
    end

    always_comb begin
        logic [SHIFT_W-1:0]         w_sh;
        logic signed [SAMPLE_W-1:0] w_t;
        w_sh    = '0;
        w_t     = '0;
        contrib = '0;
        for (int i = 0; i < NUM_WAVES; i++) begin
            w_sh = shifts[i*SHIFT_W +: SHIFT_W];
            w_t  = w_raw[i] >>> w_sh;
            // Shifting a negative entry all the way out must give 0, not -1.
            if (en && (int'(w_sh) < SAMPLE_W)) begin
                contrib = contrib + $signed({{2{w_t[SAMPLE_W-1]}}, w_t});
            end
        end
    end

endmodule

// File: rtl/nco_voice_mixer.sv
// Multi-voice NCO: per-voice phase accumulators time-share one wave
// scaler, summing one voice per cycle into a saturated output sample.
module nco_voice_mixer
    import nco_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 8,
    parameter int SAMPLE_W   = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic [NUM_VOICES*PHASE_W-1:0] fcw,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [4:0]                    sine_shift,
    input  logic [4:0]                    square_shift,
    input  logic [4:0]                    triangle_shift,
    input  logic [4:0]                    sawtooth_shift,
    output logic [SAMPLE_W-1:0]           sample_out,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + 2 + $clog2(NUM_VOICES);

    state_t                    r_state;
    logic [VIDX_W-1:0]         r_vidx;
    logic signed [ACC_W-1:0]   r_acc;
    logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
    logic [SAMPLE_W-1:0]       r_sample_out;
    logic                      r_valid;
    logic                      r_overrun;

    logic [PHASE_W-1:0]        w_phase;
    logic [PHASE_W-1:0]        w_fcw;
    logic                      w_en;
    logic                      w_last;
    logic signed [SAMPLE_W+1:0] w_contrib;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [63:0]        w_sat;

    always_comb begin
        w_phase = '0;
        w_fcw   = '0;
        w_en    = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_vidx == VIDX_W'(v)) begin
                w_phase = r_phase[v];
                w_fcw   = fcw[v*PHASE_W +: PHASE_W];
                w_en    = voice_en[v];
            end
        end
    end

    nco_wave_scaler #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .SAMPLE_W   (SAMPLE_W)
    ) u_scaler (
        .addr    (w_phase[PHASE_W-1 -: LUT_ADDR_W]),
        .en      (w_en),
        .shifts  ({sawtooth_shift, triangle_shift, square_shift, sine_shift}),
        .contrib (w_contrib)
    );

    assign w_last = (r_vidx == VIDX_W'(NUM_VOICES - 1));
    assign w_sum  = r_acc + ACC_W'(w_contrib);
    assign w_sat  = saturate(64'(w_sum), SAMPLE_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vidx       <= '0;
            r_acc        <= '0;
            r_sample_out <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
            end
        end else begin
            // A dropped tick wins over a same-cycle clear.
            if (sample_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        r_state <= ST_MIX;
                        r_acc   <= '0;
                        r_vidx  <= '0;
                    end
                end
                ST_MIX: begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if ((r_vidx == VIDX_W'(v)) && w_en) begin
                            r_phase[v] <= r_phase[v] + w_fcw;
                        end
                    end
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_state      <= ST_HOLD;
                        r_vidx       <= '0;
                        r_sample_out <= w_sat[SAMPLE_W-1:0];
                        r_valid      <= 1'b1;
                    end else begin
                        r_vidx <= r_vidx + VIDX_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_valid && sample_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_nco_voice_mixer.sv
// Scoreboard bench for nco_voice_mixer: a reference model pushes the
// expected sample per tick, a monitor pops it on each handshake.
module tb_nco_voice_mixer;

    localparam int NV = 4;
    localparam int PW = 24;
    localparam int AW = 8;
    localparam int SW = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_tick = 1'b0;
    logic [NV*PW-1:0]  fcw = '0;
    logic [NV-1:0]     voice_en = '0;
    logic [4:0]        sine_shift = '0;
    logic [4:0]        square_shift = '0;
    logic [4:0]        triangle_shift = '0;
    logic [4:0]        sawtooth_shift = '0;
    logic [SW-1:0]     sample_out;
    logic              sample_valid;
    logic              sample_ready = 1'b1;
    logic              overrun;
    logic              clr_overrun = 1'b0;

    always #5 clk = ~clk;

    nco_voice_mixer #(
        .NUM_VOICES (NV),
        .PHASE_W    (PW),
        .LUT_ADDR_W (AW),
        .SAMPLE_W   (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_tick    (sample_tick),
        .fcw            (fcw),
        .voice_en       (voice_en),
        .sine_shift     (sine_shift),
        .square_shift   (square_shift),
        .triangle_shift (triangle_shift),
        .sawtooth_shift (sawtooth_shift),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .overrun        (overrun),
        .clr_overrun    (clr_overrun)
    );

    int total = 0;
    int bad = 0;

    logic signed [SW-1:0] m_sine [256];
    logic signed [SW-1:0] m_sq   [256];
    logic signed [SW-1:0] m_tri  [256];
    logic signed [SW-1:0] m_saw  [256];
    logic [PW-1:0]        m_ph   [NV];
    logic [SW-1:0]        exp_q  [$];

    function automatic logic signed [SW-1:0] gen(input int mode);
        logic [SW-1:0] r;
        r = SW'($urandom);
        case (mode)
            0:       return $signed(r) >>> 2;
            2:       return 20'sh7FFFF;
            3:       return 20'sh80000;
            default: return $signed(r);
        endcase
    endfunction

    task automatic load_luts(input int mode);
        for (int i = 0; i < 256; i++) begin
            m_sine[i] = gen(mode);
            m_sq[i]   = gen(mode);
            m_tri[i]  = gen(mode);
            m_saw[i]  = gen(mode);
            dut.u_scaler.sine_lut[i]     = m_sine[i];
            dut.u_scaler.square_lut[i]   = m_sq[i];
            dut.u_scaler.triangle_lut[i] = m_tri[i];
            dut.u_scaler.sawtooth_lut[i] = m_saw[i];
        end
    endtask

    function automatic logic signed [31:0] term(
        input logic signed [SW-1:0] x,
        input logic [4:0]           sh
    );
        logic signed [31:0] t;
        if (sh >= 5'd20) return 32'sd0;
        t = x;
        return t >>> sh;
    endfunction

    task automatic model_push();
        logic signed [31:0] s;
        logic [7:0]         a;
        s = 0;
        for (int v = 0; v < NV; v++) begin
            if (voice_en[v]) begin
                a = m_ph[v][PW-1 -: AW];
                s = s + term(m_sine[a], sine_shift) + term(m_sq[a], square_shift)
                      + term(m_tri[a], triangle_shift) + term(m_saw[a], sawtooth_shift);
                m_ph[v] = m_ph[v] + fcw[v*PW +: PW];
            end
        end
        if (s > 32'sd524287) s = 32'sd524287;
        else if (s < -32'sd524288) s = -32'sd524288;
        exp_q.push_back(s[SW-1:0]);
    endtask

    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: unexpected sample %h, none required", sample_out);
            end else begin
                logic [SW-1:0] e;
                e = exp_q.pop_front();
                if (sample_out !== e) begin
                    bad++;
                    $display("FAIL scoreboard: sample %h, required %h", sample_out, e);
                end
            end
        end
    end

    task automatic do_sample(output logic [SW-1:0] got);
        int lat;
        @(posedge clk); #1 sample_tick = 1'b1;
        model_push();
        @(posedge clk); #1 sample_tick = 1'b0;
        lat = 1;
        while (!sample_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sample_out;
        total++;
        if (lat !== NV + 1) begin
            bad++;
            $display("FAIL latency: %0d cycles, required %0d", lat, NV + 1);
        end
        if (sample_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (sample_out !== '0) begin
            bad++; $display("FAIL reset_out: %h, required 0", sample_out);
        end
        if (sample_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: %b, required 0", sample_valid);
        end
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL reset_overrun: %b, required 0", overrun);
        end
        for (int v = 0; v < NV; v++) m_ph[v] = '0;
        rst = 1'b0;
    endtask

    task automatic test_golden();
        logic [SW-1:0] got;
        load_luts(0);
        voice_en = 4'b0001;
        fcw = '0;
        fcw[0 +: PW] = 24'h010000;
        for (int k = 0; k < 256; k++) do_sample(got);
    endtask

    task automatic test_saturation();
        logic [SW-1:0] got;
        voice_en = 4'b1111;
        for (int v = 0; v < NV; v++) fcw[v*PW +: PW] = 24'h010000;
        load_luts(2);
        for (int k = 0; k < 4; k++) begin
            do_sample(got);
            total++;
            if (got !== 20'h7FFFF) begin
                bad++; $display("FAIL sat_pos: %h, required 7ffff", got);
            end
        end
        load_luts(3);
        for (int k = 0; k < 4; k++) begin
            do_sample(got);
            total++;
            if (got !== 20'h80000) begin
                bad++; $display("FAIL sat_neg: %h, required 80000", got);
            end
        end
    endtask

    task automatic test_voice_en();
        logic [SW-1:0] got;
        logic [PW-1:0] ph1;
        logic [PW-1:0] ph3;
        load_luts(0);
        voice_en = 4'b1111;
        fcw = {24'h0ABCDE, 24'h100001, 24'h023456, 24'h010000};
        for (int k = 0; k < 3; k++) do_sample(got);
        ph1 = m_ph[1];
        ph3 = m_ph[3];
        voice_en = 4'b0101;
        for (int k = 0; k < 10; k++) do_sample(got);
        total += 2;
        if (dut.r_phase[1] !== ph1) begin
            bad++; $display("FAIL phase_v1: %h, required %h", dut.r_phase[1], ph1);
        end
        if (dut.r_phase[3] !== ph3) begin
            bad++; $display("FAIL phase_v3: %h, required %h", dut.r_phase[3], ph3);
        end
    endtask

    task automatic test_shift();
        logic [SW-1:0] got;
        load_luts(1);
        voice_en = 4'b1111;
        sine_shift = 5'd20;
        square_shift = 5'd31;
        triangle_shift = 5'd31;
        sawtooth_shift = 5'd31;
        for (int k = 0; k < 8; k++) begin
            do_sample(got);
            total++;
            if (got !== '0) begin
                bad++; $display("FAIL shift_zero: %h, required 0", got);
            end
        end
        for (int k = 0; k < 8; k++) begin
            sine_shift = 5'($urandom_range(0, 31));
            square_shift = 5'($urandom_range(0, 31));
            triangle_shift = 5'($urandom_range(0, 22));
            sawtooth_shift = 5'($urandom_range(0, 22));
            do_sample(got);
        end
        sine_shift = '0;
        square_shift = '0;
        triangle_shift = '0;
        sawtooth_shift = '0;
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] held;
        int            lat;
        load_luts(0);
        sample_ready = 1'b0;
        @(posedge clk); #1 sample_tick = 1'b1;
        model_push();
        @(posedge clk); #1 sample_tick = 1'b0;
        lat = 1;
        while (!sample_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        held = sample_out;
        for (int c = 0; c < 8; c++) begin
            sample_tick = (c == 2 || c == 5);
            @(posedge clk); #1;
            total++;
            if (sample_out !== held || sample_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable: out=%h valid=%b, required %h/1",
                         sample_out, sample_valid, held);
            end
        end
        sample_tick = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set: %b, required 1", overrun);
        end
        sample_tick = 1'b1;
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_clr_tick: %b, required 1", overrun);
        end
        clr_overrun = 1'b1;
        @(posedge clk); #1 clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_clr: %b, required 0", overrun);
        end
        sample_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (sample_valid !== 1'b0) begin
            bad++; $display("FAIL valid_drop: %b, required 0", sample_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] got;
        voice_en = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            for (int v = 0; v < NV; v++) fcw[v*PW +: PW] = PW'($urandom);
            do_sample(got);
            total++;
            if (sample_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_valid: %b, required 0", sample_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] got;
        int            seen;
        @(posedge clk); #1 sample_tick = 1'b1;
        model_push();
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total += 2;
        if (sample_out !== '0) begin
            bad++; $display("FAIL midrst_out: %h, required 0", sample_out);
        end
        if (sample_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_valid: %b, required 0", sample_valid);
        end
        void'(exp_q.pop_back());
        for (int v = 0; v < NV; v++) m_ph[v] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (sample_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL midrst_novalid: %0d valid cycles, required 0", seen);
        end
        do_sample(got);
        do_sample(got);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_saturation();
        test_voice_en();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL drain: %0d samples outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
